// File: rtl/router_pkg.sv
// ============================================================================
// Module      : router_pkg
// Description : Shared widths and state encoding for the router blocks.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package router_pkg;

    localparam int ADDR_WIDTH      = 8;
    localparam int DATA_WIDTH      = 8;
    localparam int SRAM_DATA_WIDTH = 64;
    localparam int DATA_LENGTH     = SRAM_DATA_WIDTH / DATA_WIDTH;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } out_route_state_t;

endpackage

`default_nettype wire

// File: rtl/output_router_byte_packer.sv
// ============================================================================
// Module      : byte_packer
// Description : Packs serial bytes LSB-lane-first into one registered word.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module byte_packer #(
    parameter int BYTE_WIDTH = 8,
    parameter int NUM_LANES  = 8
) (
    input  logic                            i_clk,
    input  logic                            i_nrst,
    input  logic [BYTE_WIDTH-1:0]           i_byte,
    input  logic                            i_valid,
    input  logic                            i_flush,
    input  logic                            i_clear,
    output logic [BYTE_WIDTH*NUM_LANES-1:0] o_word,
    output logic                            o_word_valid
);

    localparam int                 c_lane_bits = $clog2(NUM_LANES);
    localparam logic [c_lane_bits-1:0] c_last_lane = c_lane_bits'(NUM_LANES - 1);
    localparam logic [c_lane_bits-1:0] c_lane_one  = c_lane_bits'(1);

    logic [c_lane_bits-1:0]            r_lane;
    logic [BYTE_WIDTH*NUM_LANES-1:0]   r_pack;
    logic [BYTE_WIDTH*NUM_LANES-1:0]   w_pack_next;
    logic                              w_emit;

    always_comb begin
        w_pack_next = r_pack;
        w_pack_next[r_lane*BYTE_WIDTH +: BYTE_WIDTH] = i_byte;
    end

    assign w_emit = i_valid && (i_flush || (r_lane == c_last_lane));

    // Pack register is cleared after each emit, so a short tail is zero-padded.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_lane       <= '0;
            r_pack       <= '0;
            o_word       <= '0;
            o_word_valid <= 1'b0;
        end else if (i_clear) begin
            r_lane       <= '0;
            r_pack       <= '0;
            o_word_valid <= 1'b0;
        end else begin
            o_word_valid <= 1'b0;
            if (w_emit) begin
                o_word       <= w_pack_next;
                o_word_valid <= 1'b1;
                r_lane       <= '0;
                r_pack       <= '0;
            end else if (i_valid) begin
                r_pack <= w_pack_next;
                r_lane <= r_lane + c_lane_one;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/sram.sv
// ============================================================================
// Module      : sram
// Description : Single-clock simple dual-port SRAM, registered read with valid.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sram #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 64
) (
    input  logic                  i_clk,
    input  logic                  i_nrst,
    input  logic                  i_wr_en,
    input  logic [ADDR_WIDTH-1:0] i_wr_addr,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic                  i_rd_en,
    input  logic [ADDR_WIDTH-1:0] i_rd_addr,
    output logic [DATA_WIDTH-1:0] o_rd_data,
    output logic                  o_rd_valid
);

    logic [DATA_WIDTH-1:0] r_mem [0:(2**ADDR_WIDTH)-1];

    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Array itself is not reset; only the read-side output registers are.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            o_rd_data  <= '0;
            o_rd_valid <= 1'b0;
        end else begin
            o_rd_valid <= i_rd_en;
            if (i_rd_en) begin
                o_rd_data <= r_mem[i_rd_addr];
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/output_router.sv
// ============================================================================
// Module      : output_router
// Description : Packs PE result bytes into 64-bit words, stores them in an
//               output SRAM from a start address, and serves host reads.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module output_router
    import router_pkg::*;
(
    input  logic                       i_clk,
    input  logic                       i_nrst,
    input  logic                       i_reg_clear,
    input  logic                       i_route_en,
    input  logic [ADDR_WIDTH-1:0]      i_start_addr,
    input  logic [ADDR_WIDTH-1:0]      i_route_size,
    input  logic [DATA_WIDTH-1:0]      i_data,
    input  logic                       i_data_valid,
    input  logic                       i_read_en,
    input  logic [ADDR_WIDTH-1:0]      i_read_addr,
    output logic [SRAM_DATA_WIDTH-1:0] o_data_out,
    output logic                       o_data_out_valid,
    output logic                       o_busy,
    output logic                       o_route_done,
    output logic                       o_drop
);

    localparam logic [ADDR_WIDTH-1:0] c_addr_one  = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] c_addr_zero = '0;

    out_route_state_t             r_state;
    out_route_state_t             w_state_next;
    logic [ADDR_WIDTH-1:0]        r_wr_ptr;
    logic [ADDR_WIDTH-1:0]        r_remaining;
    logic                         r_route_done;
    logic                         r_drop;
    logic                         w_start;
    logic                         w_accept;
    logic                         w_flush;
    logic                         w_packer_clear;
    logic                         w_wr_en;
    logic [SRAM_DATA_WIDTH-1:0]   w_word;
    logic                         w_word_valid;

    assign w_start        = (r_state == IDLE) && i_route_en && !i_reg_clear;
    assign w_accept       = i_data_valid && (r_state == COLLECT);
    assign w_flush        = w_accept && (r_remaining == c_addr_one);
    assign w_packer_clear = i_reg_clear || w_start;
    // A word still in flight when clear arrives is dropped, not written.
    assign w_wr_en        = w_word_valid && !i_reg_clear;

    always_comb begin
        w_state_next = r_state;
        if (i_reg_clear) begin
            w_state_next = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_route_en) begin
                        w_state_next = (i_route_size == c_addr_zero) ? DONE : COLLECT;
                    end
                end
                COLLECT: begin
                    if (w_flush) begin
                        w_state_next = DONE;
                    end
                end
                DONE:    w_state_next = DONE;
                default: w_state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_wr_ptr    <= '0;
            r_remaining <= '0;
        end else begin
            if (w_start) begin
                r_wr_ptr    <= i_start_addr;
                r_remaining <= i_route_size;
            end else begin
                if (w_wr_en) begin
                    r_wr_ptr <= r_wr_ptr + c_addr_one;
                end
                if (w_accept) begin
                    r_remaining <= r_remaining - c_addr_one;
                end
            end
        end
    end

    // Done trails DONE entry by one cycle so the last write lands first;
    // an empty route has no write and reports done immediately.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_route_done <= 1'b0;
            r_drop       <= 1'b0;
        end else if (i_reg_clear) begin
            r_route_done <= 1'b0;
            r_drop       <= 1'b0;
        end else begin
            if ((w_start && (i_route_size == c_addr_zero)) || (r_state == DONE)) begin
                r_route_done <= 1'b1;
            end
            if (i_data_valid && (r_state != COLLECT)) begin
                r_drop <= 1'b1;
            end
        end
    end

    byte_packer #(
        .BYTE_WIDTH (DATA_WIDTH),
        .NUM_LANES  (DATA_LENGTH)
    ) u_byte_packer (
        .i_clk        (i_clk),
        .i_nrst       (i_nrst),
        .i_byte       (i_data),
        .i_valid      (w_accept),
        .i_flush      (w_flush),
        .i_clear      (w_packer_clear),
        .o_word       (w_word),
        .o_word_valid (w_word_valid)
    );

    sram #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (SRAM_DATA_WIDTH)
    ) u_out_sram (
        .i_clk      (i_clk),
        .i_nrst     (i_nrst),
        .i_wr_en    (w_wr_en),
        .i_wr_addr  (r_wr_ptr),
        .i_wr_data  (w_word),
        .i_rd_en    (i_read_en),
        .i_rd_addr  (i_read_addr),
        .o_rd_data  (o_data_out),
        .o_rd_valid (o_data_out_valid)
    );

    assign o_busy       = (r_state == COLLECT);
    assign o_route_done = r_route_done;
    assign o_drop       = r_drop;

endmodule

`default_nettype wire

// File: doc/output_router.md
# output_router

Output-side counterpart of the weight router. It accepts the serial 8-bit result stream from the PE array and packs eight results into one 64-bit word. Each full word is written to an internal output SRAM at consecutive addresses from a programmed start address, and the host reads results back through a separate read port. It sits between the PE array output and the host/DMA read path.

## Interface
- ADDR_WIDTH, 8, SRAM address width; also the width of the route-size field
- DATA_WIDTH, 8, width of one result byte
- SRAM_DATA_WIDTH, 64, width of one SRAM word
- DATA_LENGTH, SRAM_DATA_WIDTH/DATA_WIDTH = 8, lanes per word
- i_clk  in  1  single clock, rising edge
- i_nrst  in  1  asynchronous active-low reset
- i_reg_clear  in  1  synchronous clear; aborts the route and drops any partial word
- i_route_en  in  1  start a route when in IDLE
- i_start_addr  in  ADDR_WIDTH  first SRAM word address; sampled on start
- i_route_size  in  ADDR_WIDTH  number of bytes in the route; sampled on start
- i_data  in  DATA_WIDTH  result byte
- i_data_valid  in  1  i_data is valid this cycle
- i_read_en  in  1  host read request
- i_read_addr  in  ADDR_WIDTH  host read address
- o_data_out  out  SRAM_DATA_WIDTH  host read data
- o_data_out_valid  out  1  host read data valid
- o_busy  out  1  route in progress (COLLECT state)
- o_route_done  out  1  route complete; sticky
- o_drop  out  1  sticky flag; a valid byte arrived outside COLLECT

## Operation
- States: IDLE, COLLECT, DONE.
- **IDLE**
  - i_route_en=1 latches the start address into the write pointer and the size into the remaining count.
  - Lane index and the pack register are cleared.
  - Next state is COLLECT, or DONE if i_route_size=0.
- **COLLECT**
  - Each cycle with i_data_valid=1, the byte is stored in lane `lane`, at bits [8*lane+7 : 8*lane]. Lane 0 is the LSB.
  - lane then increments and remaining decrements.
  - When the 8th lane fills, or remaining reaches 0:
    - The word is written to the SRAM at the write pointer.
    - The write pointer increments modulo 2^ADDR_WIDTH.
    - lane and the pack register clear.
  - A partial final word is zero-padded in its unused lanes.
  - After the final byte, the next state is DONE.
  - There is no backpressure: every valid byte in COLLECT is accepted.
- **DONE**
  - o_route_done=1, and it holds until i_reg_clear.
  - i_route_en is ignored.
- Valid bytes arriving in IDLE or DONE are discarded and set o_drop. o_drop clears only on i_reg_clear or reset.
- **i_reg_clear** has priority over everything else in every state:
  - Next state is IDLE.
  - The partial word is discarded and not written.
  - o_route_done and o_drop clear.
  - SRAM contents are untouched.
- **Host read port** is independent of the route state. Reading an address while this block is writing it in the same cycle gives unspecified data. The host reads only after o_route_done.

## Timing
- **Reset values:** all outputs 0; state IDLE; pointers, counters and pack register 0.
- **Start:** i_route_en sampled at edge t puts the block in COLLECT from cycle t+1. The first byte can be accepted in cycle t+1.
- **Write latency:**
  - A byte that completes a word, accepted at edge k, produces the SRAM write enable in cycle k+1 (registered).
  - The data is stored at edge k+1.
- **Done:** o_route_done rises in cycle k+2 after the final byte. Data is then readable by the host.
- **Host read latency:** i_read_en at edge r gives o_data_out and o_data_out_valid=1 in cycle r+1 for one cycle.
- **Back-to-back words:** valid bytes on every cycle sustain one SRAM write every 8 cycles with no bubbles.
- **Size 0:** DONE is entered at t+1 with no writes; o_route_done=1 from t+1.

## Structure
- **Shared package (router_pkg):**
  - Width constants ADDR_WIDTH, DATA_WIDTH, SRAM_DATA_WIDTH, DATA_LENGTH.
  - State enum `out_route_state_t` {IDLE, COLLECT, DONE}.
- **SRAM:** instantiate the existing `sram` module (ADDR_WIDTH, SRAM_DATA_WIDTH) for the output buffer.
- **Sub-module `byte_packer`:**
  - Holds the lane counter and pack register.
  - Inputs: byte, valid, flush, clear.
  - Outputs: packed word and word-valid.
  - The top level keeps the FSM, write pointer and remaining count.

## Test plan
- **Single full word:** start 0x10, size 8, bytes 0x01..0x08 on consecutive cycles.
  - One write to 0x10 with data 0x0807060504030201.
  - Done 2 cycles after the last byte.
  - Host read of 0x10 returns that word.
- **Partial tail:** start 0x20, size 10, bytes 0x01..0x0A.
  - Write to 0x20 with 0x0807060504030201.
  - Write to 0x21 with 0x0000000000000A09.
  - Exactly 2 writes.
- **Gapped valid:** same stimulus as the partial-tail case, with i_data_valid toggling every cycle. SRAM contents are identical; done is delayed accordingly.
- **Address wrap:** start 0xFF, size 16. Writes land at 0xFF then 0x00.
- **Abort:** i_reg_clear after 5 bytes of a size-8 route.
  - No SRAM write; IDLE; done=0.
  - A following size-8 route at 0x30 writes correctly with no leftover lanes.
- **Edge events:**
  - Size 0 gives done at t+1 with no write.
  - A valid byte in IDLE sets o_drop=1 and writes nothing.
  - i_reg_clear clears o_drop.
  - Asynchronous reset in the middle of COLLECT zeros all outputs immediately.
